// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared widths, FSM states and range check for the memory access unit
package mem_access_unit_pkg;

  localparam int ADDR_W            = 16;
  localparam int DATA_W            = 16;
  localparam int MEM_BYTES_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RDW,
    ST_WR,
    ST_RESP
  } state_t;

  // A word touches addr and addr+1, so its last legal start is one byte earlier than a byte's.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input logic is_byte,
                                         input int mem_bytes);
    logic [31:0] last;
    last = is_byte ? 32'(mem_bytes - 1) : 32'(mem_bytes - 2);
    return {{(32-ADDR_W){1'b0}}, addr} <= last;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - datapath request/response handshake into the memory access unit
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_byte;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian byte lane handling: store merge and load extension
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [7:0]        wbyte,
  input  logic              is_byte,
  input  logic              is_signed,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  // The addressed byte sits in the upper lane; the lower lane belongs to addr+1.
  always_comb begin
    load_data  = is_byte ? {{8{is_signed & rdata[15]}}, rdata[15:8]} : rdata;
    merge_data = {wbyte, rdata[7:0]};
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store initiator for the Data_Memory port
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t            state;
  logic              r_write;
  logic              r_byte;
  logic              r_signed;
  logic [7:0]        r_wbyte;
  logic              rd_q;
  logic              wr_q;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;

  mem_lane_align u_lane_align (
    .rdata      (mem_read_data),
    .wbyte      (r_wbyte),
    .is_byte    (r_byte),
    .is_signed  (r_signed),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign bus.req_ready = (state == ST_IDLE);
  // Gating with rst keeps a reset cycle from committing a write to memory.
  assign mem_read      = rd_q & ~rst;
  assign mem_write     = wr_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      r_write        <= 1'b0;
      r_byte         <= 1'b0;
      r_signed       <= 1'b0;
      r_wbyte        <= '0;
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      rd_q           <= 1'b0;
      wr_q           <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_write  <= bus.req_write;
            r_byte   <= bus.req_byte;
            r_signed <= bus.req_signed;
            r_wbyte  <= bus.req_wdata[7:0];
            if (!addr_in_range(bus.req_addr, bus.req_byte, MEM_BYTES)) begin
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
              state          <= ST_RESP;
            end else begin
              mem_address <= bus.req_addr;
              if (bus.req_write && !bus.req_byte) begin
                mem_write_data <= bus.req_wdata;
                wr_q           <= 1'b1;
                state          <= ST_WR;
              end else begin
                rd_q  <= 1'b1;
                state <= ST_RD;
              end
            end
          end
        end
        ST_RD: state <= ST_RDW;
        ST_RDW: begin
          if (r_write) begin
            mem_write_data <= merge_data;
            wr_q           <= 1'b1;
            state          <= ST_WR;
          end else begin
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= load_data;
            state          <= ST_RESP;
          end
        end
        ST_WR: begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
          state          <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench with byte-array memory and reference model
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data = 16'h0000;
  logic        mem_write;
  logic        mem_read;

  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_BYTES(MB)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  // Data_Memory model: byte array, registered big-endian word read.
  logic [7:0] dmem [MB];
  bit         mem_init_done = 1'b0;

  function automatic logic [7:0] rdb(input int a);
    return (a < MB) ? dmem[10'(a)] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < MB; i++) dmem[i] <= 8'($urandom);
      mem_init_done <= 1'b1;
    end
    if (mem_read) mem_read_data <= {rdb(int'(mem_address)), rdb(int'(mem_address) + 1)};
    if (mem_write) begin
      if (int'(mem_address) < MB) dmem[10'(mem_address)] <= mem_write_data[15:8];
      if (int'(mem_address) + 1 < MB) dmem[10'(int'(mem_address) + 1)] <= mem_write_data[7:0];
    end
  end

  // Reference model
  typedef struct {
    logic        w;
    logic        b;
    logic        s;
    logic [15:0] a;
    logic [15:0] d;
  } req_t;

  typedef struct {
    req_t        r;
    logic        err;
    logic [15:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  logic [7:0] ref_mem [MB];
  bit         ref_init = 1'b0;
  exp_t       q[$];

  function automatic logic [7:0] refb(input int a);
    return (a < MB) ? ref_mem[10'(a)] : 8'h00;
  endfunction

  function automatic exp_t model(input req_t r, input int acc);
    exp_t       e;
    int         a;
    logic [7:0] bb;
    a       = int'(r.a);
    e.r     = r;
    e.acc   = acc;
    e.err   = r.b ? (a > MB - 1) : (a > MB - 2);
    e.rdata = 16'h0000;
    if (e.err) e.lat = 1;
    else if (r.w) e.lat = r.b ? 4 : 2;
    else begin
      e.lat = 3;
      if (r.b) begin
        bb      = refb(a);
        e.rdata = {(r.s && bb[7]) ? 8'hFF : 8'h00, bb};
      end else begin
        e.rdata = {refb(a), refb(a + 1)};
      end
    end
    return e;
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor / scoreboard
  int          cyc = 0, both_hi = 0, ready_viol = 0, unexp = 0;
  int          rd_cnt = 0, wr_cnt = 0, last_rd_cyc = 0, last_wr_cyc = 0;
  int          acc_cnt = 0, resp_cnt = 0, last_lat = 0, pcyc = 0;
  logic [15:0] last_wr_data = 16'h0000, last_rdata = 16'h0000;
  logic        last_err = 1'b0;
  bit          pending = 1'b0;
  req_t        preq;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!ref_init && mem_init_done) begin
        ref_mem  = dmem;
        ref_init = 1'b1;
      end
      if (mem_read && mem_write) both_hi++;
      if (mem_read) begin rd_cnt++; last_rd_cyc = cyc; end
      if (mem_write) begin wr_cnt++; last_wr_cyc = cyc; last_wr_data = mem_write_data; end
      if (rst) begin
        q.delete();
        pending = 1'b0;
      end else begin
        if (pending) begin
          q.push_back(model(preq, pcyc));
          acc_cnt++;
        end
        if (q.size() != 0 && bus.req_ready) ready_viol++;
        if (bus.resp_valid) begin
          resp_cnt++;
          if (q.size() == 0) unexp++;
          else begin
            e = q.pop_front();
            check_eq("resp_latency", cyc - e.acc, e.lat);
            check_eq("resp_rdata", bus.resp_rdata, e.rdata);
            check_eq("resp_err", bus.resp_err, e.err);
            last_lat   = cyc - e.acc;
            last_rdata = bus.resp_rdata;
            last_err   = bus.resp_err;
            if (!e.err && e.r.w) begin
              ref_mem[10'(e.r.a)] = e.r.b ? e.r.d[7:0] : e.r.d[15:8];
              if (!e.r.b) ref_mem[10'(int'(e.r.a) + 1)] = e.r.d[7:0];
            end
          end
        end else if (q.size() != 0 && cyc - q[0].acc > 8) begin
          check_eq("resp_timeout", cyc - q[0].acc, q[0].lat);
          void'(q.pop_front());
        end
        pending = bus.req_valid && bus.req_ready;
        if (pending) begin
          preq.w = bus.req_write;
          preq.b = bus.req_byte;
          preq.s = bus.req_signed;
          preq.a = bus.req_addr;
          preq.d = bus.req_wdata;
          pcyc   = cyc;
        end
      end
    end
  end

  // Driver: fields change 1 time unit after a posedge, acceptance seen at the next posedge.
  task automatic send(input logic w, input logic b, input logic s, input logic [15:0] a,
                      input logic [15:0] d, input bit hold);
    int n;
    n              = 0;
    bus.req_write  = w;
    bus.req_byte   = b;
    bus.req_signed = s;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      check_eq("req_ready_wait", n, 0);
      bus.req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      if (!hold) bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q.size() != 0 || pending) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || pending) begin
      check_eq("outstanding_requests", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic txn(input logic w, input logic b, input logic s, input logic [15:0] a,
                     input logic [15:0] d);
    @(posedge clk);
    #1;
    send(w, b, s, a, d, 1'b0);
    wait_done();
  endtask

  initial begin
    int          r0, w0, rc, ac, wc, mm;
    logic [7:0]  b40, b41;
    bit          prev_hold;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_byte   = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 16'h0000;
    bus.req_wdata  = 16'h0000;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_resp_err", bus.resp_err, 0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 0);
    check_eq("rst_mem_read", mem_read, 0);
    check_eq("rst_mem_write", mem_write, 0);
    check_eq("rst_mem_address", mem_address, 0);
    check_eq("rst_mem_write_data", mem_write_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_req_ready", bus.req_ready, 1);

    // Word store then word load
    txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234);
    check_eq("t1_mem10", dmem[16], 8'h12);
    check_eq("t1_mem11", dmem[17], 8'h34);
    check_eq("t1_store_latency", last_lat, 2);
    txn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000);
    check_eq("t1_load_rdata", last_rdata, 16'h1234);
    check_eq("t1_load_latency", last_lat, 3);

    // Byte store as read-modify-write
    txn(1'b1, 1'b0, 1'b0, 16'h0020, 16'hABCD);
    r0 = rd_cnt;
    w0 = wr_cnt;
    txn(1'b1, 1'b1, 1'b0, 16'h0020, 16'h5577);
    check_eq("t2_read_count", rd_cnt - r0, 1);
    check_eq("t2_write_count", wr_cnt - w0, 1);
    check_eq("t2_read_before_write", last_wr_cyc > last_rd_cyc, 1);
    check_eq("t2_write_data", last_wr_data, 16'h77CD);
    check_eq("t2_mem20", dmem[32], 8'h77);
    check_eq("t2_mem21", dmem[33], 8'hCD);
    check_eq("t2_latency", last_lat, 4);

    // Byte loads, signed and unsigned
    txn(1'b1, 1'b0, 1'b0, 16'h0030, 16'h8011);
    txn(1'b0, 1'b1, 1'b1, 16'h0030, 16'h0000);
    check_eq("t3_signed", last_rdata, 16'hFF80);
    txn(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0000);
    check_eq("t3_unsigned", last_rdata, 16'h0080);

    // Range boundary
    r0 = rd_cnt;
    w0 = wr_cnt;
    txn(1'b0, 1'b0, 1'b0, 16'h03FF, 16'h0000);
    check_eq("t4_word_err", last_err, 1);
    check_eq("t4_err_latency", last_lat, 1);
    check_eq("t4_err_no_strobes", (rd_cnt - r0) + (wr_cnt - w0), 0);
    txn(1'b0, 1'b1, 1'b0, 16'h03FF, 16'h0000);
    check_eq("t4_byte_ok", last_err, 0);
    txn(1'b0, 1'b0, 1'b0, 16'h03FE, 16'h0000);
    check_eq("t4_word_last_ok", last_err, 0);
    txn(1'b1, 1'b1, 1'b0, 16'h03FF, 16'h00A5);
    check_eq("t4_byte_store_last", dmem[1023], 8'hA5);
    txn(1'b1, 1'b0, 1'b0, 16'h0400, 16'h1111);
    check_eq("t4_store_err", last_err, 1);

    // Reset during the WR cycle of a word store
    @(posedge clk);
    #1;
    b40 = dmem[64];
    b41 = dmem[65];
    rc  = resp_cnt;
    wc  = wr_cnt;
    bus.req_write  = 1'b1;
    bus.req_byte   = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 16'h0040;
    bus.req_wdata  = 16'hBEEF;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    check_eq("t5_ready_before", bus.req_ready, 1);
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_ready_after_rst", bus.req_ready, 1);
    repeat (6) @(negedge clk);
    check_eq("t5_no_resp", resp_cnt - rc, 0);
    check_eq("t5_no_write", wr_cnt - wc, 0);
    check_eq("t5_mem40", dmem[64], b40);
    check_eq("t5_mem41", dmem[65], b41);

    // Back-to-back with req_valid held
    @(posedge clk);
    #1;
    rc = resp_cnt;
    ac = acc_cnt;
    send(1'b1, 1'b0, 1'b0, 16'h0050, 16'($urandom), 1'b1);
    send(1'b0, 1'b0, 1'b0, 16'h0050, 16'h0000, 1'b1);
    send(1'b0, 1'b1, 1'b1, 16'h0050, 16'h0000, 1'b0);
    wait_done();
    check_eq("t6_accepts", acc_cnt - ac, 3);
    check_eq("t6_responses", resp_cnt - rc, 3);

    // Randomized traffic
    prev_hold = 1'b0;
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      bit          hold;
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1016, 1030))
                                      : 16'($urandom_range(0, 1023));
      hold = ($urandom_range(0, 2) == 0) && (i != 59);
      if (!prev_hold) begin
        @(posedge clk);
        #1;
      end
      send(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), hold);
      if (!hold) wait_done();
      prev_hold = hold;
    end
    bus.req_valid = 1'b0;
    wait_done();

    mm = 0;
    for (int i = 0; i < MB; i++) if (dmem[i] !== ref_mem[i]) mm++;
    check_eq("mem_image_mismatches", mm, 0);
    check_eq("read_write_overlap", both_hi, 0);
    check_eq("ready_while_busy", ready_viol, 0);
    check_eq("unexpected_resp", unexp, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
